// File: rtl/dr_mem_hs_if.sv
// Handshake and dual-rail bus bundle between the datapath side (master) and
// the dual-rail memory (slave).
interface dr_mem_hs_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic [2*ADDR_W-1:0] addr_dr;
   logic [2*DATA_W-1:0] data_in_dr;
   logic                req_write;
   logic                req_read;
   logic                ack_in_read;
   logic                ack_write;
   logic                ack_read;
   logic [2*DATA_W-1:0] data_out_dr;
   logic                err;

   modport master (
      output addr_dr,
      output data_in_dr,
      output req_write,
      output req_read,
      output ack_in_read,
      input  ack_write,
      input  ack_read,
      input  data_out_dr,
      input  err
   );

   modport slave (
      input  addr_dr,
      input  data_in_dr,
      input  req_write,
      input  req_read,
      input  ack_in_read,
      output ack_write,
      output ack_read,
      output data_out_dr,
      output err
   );
endinterface

// File: rtl/dr_mem_hs.sv
// Clocked dual-rail memory with independent four-phase read and write
// handshakes, code checking and a sticky illegal-code flag.
module dr_mem_hs #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   dr_mem_hs_if.slave  bus_io
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WACK = 2'd1,
      RACK = 2'd2
   } state_t;

   function automatic logic addr_is_valid(input logic [2*ADDR_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < ADDR_W; i++) begin
         ok = ok & (v[2*i+1] ^ v[2*i]);
      end
      return ok;
   endfunction

   function automatic logic addr_is_illegal(input logic [2*ADDR_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < ADDR_W; i++) begin
         bad = bad | (v[2*i+1] & v[2*i]);
      end
      return bad;
   endfunction

   function automatic logic data_is_valid(input logic [2*DATA_W-1:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DATA_W; i++) begin
         ok = ok & (v[2*i+1] ^ v[2*i]);
      end
      return ok;
   endfunction

   function automatic logic data_is_illegal(input logic [2*DATA_W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         bad = bad | (v[2*i+1] & v[2*i]);
      end
      return bad;
   endfunction

   // Decoding takes only the true rails; callers qualify validity first.
   function automatic logic [ADDR_W-1:0] addr_decode(input logic [2*ADDR_W-1:0] v);
      logic [ADDR_W-1:0] r;
      r = {ADDR_W{1'b0}};
      for (int i = 0; i < ADDR_W; i++) begin
         r[i] = v[2*i+1];
      end
      return r;
   endfunction

   function automatic logic [DATA_W-1:0] data_decode(input logic [2*DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      r = {DATA_W{1'b0}};
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = v[2*i+1];
      end
      return r;
   endfunction

   function automatic logic [2*DATA_W-1:0] data_encode(input logic [DATA_W-1:0] b);
      logic [2*DATA_W-1:0] r;
      r = {(2*DATA_W){1'b0}};
      for (int i = 0; i < DATA_W; i++) begin
         r[2*i+1] = b[i];
         r[2*i]   = ~b[i];
      end
      return r;
   endfunction

   state_t              state_q, state_d;
   logic                ack_write_q, ack_write_d;
   logic                ack_read_q, ack_read_d;
   logic [2*DATA_W-1:0] data_out_q, data_out_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                addr_valid;
   logic                addr_illegal;
   logic                addr_null;
   logic                data_valid;
   logic                data_illegal;
   logic                data_null;
   logic [ADDR_W-1:0]   addr_dec;
   logic [DATA_W-1:0]   data_dec;
   logic                wr_bad;
   logic                rd_bad;
   logic                wr_en;

   assign addr_valid   = addr_is_valid(bus_io.addr_dr);
   assign addr_illegal = addr_is_illegal(bus_io.addr_dr);
   assign addr_null    = (bus_io.addr_dr == {(2*ADDR_W){1'b0}});
   assign data_valid   = data_is_valid(bus_io.data_in_dr);
   assign data_illegal = data_is_illegal(bus_io.data_in_dr);
   assign data_null    = (bus_io.data_in_dr == {(2*DATA_W){1'b0}});
   assign addr_dec     = addr_decode(bus_io.addr_dr);
   assign data_dec     = data_decode(bus_io.data_in_dr);

   // Any active request touching an illegal bus blocks all action that edge.
   assign wr_bad = bus_io.req_write & (addr_illegal | data_illegal);
   assign rd_bad = bus_io.req_read & addr_illegal;

   always_comb begin
      state_d     = state_q;
      ack_write_d = ack_write_q;
      ack_read_d  = ack_read_q;
      data_out_d  = data_out_q;
      err_d       = err_q;
      wr_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (wr_bad || rd_bad) begin
               err_d = 1'b1;
            end else if (bus_io.req_write && addr_valid && data_valid) begin
               wr_en       = 1'b1;
               ack_write_d = 1'b1;
               state_d     = WACK;
            end else if (bus_io.req_read && addr_valid && !bus_io.ack_in_read) begin
               data_out_d = data_encode(mem_q[addr_dec]);
               ack_read_d = 1'b1;
               state_d    = RACK;
            end else begin
               state_d = IDLE;
            end
         end
         WACK: begin
            if (!bus_io.req_write && addr_null && data_null) begin
               ack_write_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d = WACK;
            end
         end
         RACK: begin
            if (!bus_io.req_read && bus_io.ack_in_read) begin
               ack_read_d = 1'b0;
               data_out_d = {(2*DATA_W){1'b0}};
               state_d    = IDLE;
            end else begin
               state_d = RACK;
            end
         end
         default: begin
            state_d     = IDLE;
            ack_write_d = 1'b0;
            ack_read_d  = 1'b0;
            data_out_d  = {(2*DATA_W){1'b0}};
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         ack_write_q <= 1'b0;
         ack_read_q  <= 1'b0;
         data_out_q  <= {(2*DATA_W){1'b0}};
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ack_write_q <= ack_write_d;
         ack_read_q  <= ack_read_d;
         data_out_q  <= data_out_d;
         err_q       <= err_d;
      end
   end

   // Storage is cleared on reset so a read after reset returns encoded zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else if (wr_en) begin
         mem_q[addr_dec] <= data_dec;
      end
   end

   assign bus_io.ack_write   = ack_write_q;
   assign bus_io.ack_read    = ack_read_q;
   assign bus_io.data_out_dr = data_out_q;
   assign bus_io.err         = err_q;

endmodule

// File: tb/tb_dr_mem_hs.sv
// Self-checking bench for dr_mem_hs: directed handshake scenarios with literal
// expectations, then randomized traffic compared every cycle to a reference model.
module tb_dr_mem_hs;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;

   dr_mem_hs_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   dr_mem_hs #(.DATA_W(8), .ADDR_W(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   // Reference encoding by arithmetic: logic 1 -> pair value 2, logic 0 -> pair value 1.
   function automatic logic [15:0] enc_d(input int val, input int nbits);
      int r;
      r = 0;
      for (int i = 0; i < nbits; i++) begin
         r = r + ((((val >> i) & 1) == 1 ? 2 : 1) << (2 * i));
      end
      return r[15:0];
   endfunction

   function automatic int dec_d(input logic [15:0] v, input int nbits);
      int r;
      r = 0;
      for (int i = 0; i < nbits; i++) begin
         if (((int'(v) >> (2 * i)) & 3) == 2) r = r + (1 << i);
      end
      return r;
   endfunction

   // 0 = null/partial, 1 = valid, 2 = illegal
   function automatic int classify(input logic [15:0] v, input int nbits);
      int nulls;
      int p;
      nulls = 0;
      for (int i = 0; i < nbits; i++) begin
         p = (int'(v) >> (2 * i)) & 3;
         if (p == 3) return 2;
         if (p == 0) nulls++;
      end
      return (nulls == 0) ? 1 : 0;
   endfunction

   // Behavioural model: two busy flags, a byte array and the sticky error.
   int          mem_m [16];
   bit          m_aw, m_ar, m_err;
   logic [15:0] m_dout;

   always @(posedge clk or posedge rst) begin
      int ac, dc;
      if (rst) begin
         m_aw = 1'b0; m_ar = 1'b0; m_err = 1'b0; m_dout = 16'h0000;
         for (int i = 0; i < 16; i++) mem_m[i] = 0;
      end else if (m_aw) begin
         if (!bus.req_write && bus.addr_dr == 8'h00 && bus.data_in_dr == 16'h0000) m_aw = 1'b0;
      end else if (m_ar) begin
         if (!bus.req_read && bus.ack_in_read) begin
            m_ar = 1'b0;
            m_dout = 16'h0000;
         end
      end else begin
         ac = classify({8'h00, bus.addr_dr}, 4);
         dc = classify(bus.data_in_dr, 8);
         if ((bus.req_write && (ac == 2 || dc == 2)) || (bus.req_read && ac == 2)) begin
            m_err = 1'b1;
         end else if (bus.req_write && ac == 1 && dc == 1) begin
            mem_m[dec_d({8'h00, bus.addr_dr}, 4)] = dec_d(bus.data_in_dr, 8);
            m_aw = 1'b1;
         end else if (bus.req_read && ac == 1 && !bus.ack_in_read) begin
            m_dout = enc_d(mem_m[dec_d({8'h00, bus.addr_dr}, 4)], 8);
            m_ar = 1'b1;
         end
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_ack_write", {31'd0, bus.ack_write}, {31'd0, m_aw});
         chk("m_ack_read", {31'd0, bus.ack_read}, {31'd0, m_ar});
         chk("m_data_out", {16'd0, bus.data_out_dr}, {16'd0, m_dout});
         chk("m_err", {31'd0, bus.err}, {31'd0, m_err});
      end
   end

   task automatic idle_bus();
      bus.addr_dr = 8'h00; bus.data_in_dr = 16'h0000;
      bus.req_write = 1'b0; bus.req_read = 1'b0; bus.ack_in_read = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic wr(input int a, input int d);
      logic [15:0] ea;
      ea = enc_d(a, 4);
      bus.addr_dr = ea[7:0]; bus.data_in_dr = enc_d(d, 8); bus.req_write = 1'b1;
      step();
      chk("wr_ack_rise", {31'd0, bus.ack_write}, 32'd1);
      bus.req_write = 1'b0; bus.addr_dr = 8'h00; bus.data_in_dr = 16'h0000;
      step();
      chk("wr_ack_fall", {31'd0, bus.ack_write}, 32'd0);
   endtask

   task automatic rd(input int a, input logic [15:0] exp);
      logic [15:0] ea;
      ea = enc_d(a, 4);
      bus.addr_dr = ea[7:0]; bus.req_read = 1'b1; bus.ack_in_read = 1'b0;
      step();
      chk("rd_ack_rise", {31'd0, bus.ack_read}, 32'd1);
      chk("rd_data", {16'd0, bus.data_out_dr}, {16'd0, exp});
      bus.req_read = 1'b0; bus.ack_in_read = 1'b1; bus.addr_dr = 8'h00;
      step();
      chk("rd_ack_fall", {31'd0, bus.ack_read}, 32'd0);
      chk("rd_null", {16'd0, bus.data_out_dr}, 32'd0);
      bus.ack_in_read = 1'b0;
   endtask

   function automatic logic [15:0] rnd_bus(input int nbits);
      logic [15:0] v;
      int r, k;
      r = $urandom_range(0, 99);
      if (r < 30) return 16'h0000;
      v = enc_d($urandom_range(0, (1 << nbits) - 1), nbits);
      k = $urandom_range(0, nbits - 1);
      if (r < 40) v = v & ~(16'h0003 << (2 * k));
      else if (r < 41) v = v | (16'h0003 << (2 * k));
      return v;
   endfunction

   initial begin
      logic [15:0] t;
      idle_bus();
      #1 rst = 1'b1;
      #1 chk_en = 1'b1;
      step(); step();
      chk("rst_ack_write", {31'd0, bus.ack_write}, 32'd0);
      chk("rst_ack_read", {31'd0, bus.ack_read}, 32'd0);
      chk("rst_data", {16'd0, bus.data_out_dr}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      rst = 1'b0;
      step();

      // Reset then read addr 3 (01_01_10_10)
      chk("enc_addr3", {16'd0, enc_d(3, 4)}, 32'h005A);
      rd(3, 16'h5555);

      // Write/read-back
      wr(9, 8'hA5);
      rd(9, 16'h9966);

      // Simultaneous requests: write first, read after release
      bus.addr_dr = 8'h59; bus.data_in_dr = enc_d(8'h3C, 8);
      bus.req_write = 1'b1; bus.req_read = 1'b1; bus.ack_in_read = 1'b0;
      step();
      chk("sim_ack_write", {31'd0, bus.ack_write}, 32'd1);
      chk("sim_ack_read_low", {31'd0, bus.ack_read}, 32'd0);
      bus.req_write = 1'b0; bus.addr_dr = 8'h00; bus.data_in_dr = 16'h0000;
      step();
      chk("sim_wack_fall", {31'd0, bus.ack_write}, 32'd0);
      chk("sim_read_wait", {31'd0, bus.ack_read}, 32'd0);
      bus.addr_dr = 8'h59;
      step();
      chk("sim_ack_read", {31'd0, bus.ack_read}, 32'd1);
      chk("sim_data", {16'd0, bus.data_out_dr}, 32'h5AA5);
      bus.req_read = 1'b0; bus.ack_in_read = 1'b1; bus.addr_dr = 8'h00;
      step();
      bus.ack_in_read = 1'b0;

      // Partial address: wait, no error
      bus.addr_dr = 8'h58; bus.req_read = 1'b1;
      step(); step();
      chk("part_no_ack", {31'd0, bus.ack_read}, 32'd0);
      chk("part_no_err", {31'd0, bus.err}, 32'd0);
      bus.req_read = 1'b0; bus.addr_dr = 8'h00;
      step();

      // Illegal data pair on a write: err, no write
      bus.addr_dr = 8'h96; bus.data_in_dr = 16'hAAAB; bus.req_write = 1'b1;
      step();
      chk("ill_err", {31'd0, bus.err}, 32'd1);
      chk("ill_no_ack", {31'd0, bus.ack_write}, 32'd0);
      idle_bus();
      step();
      rd(9, 16'h9966);
      chk("ill_err_sticky", {31'd0, bus.err}, 32'd1);

      // Read hold-off, then early req drop keeps data held
      bus.addr_dr = 8'h5A; bus.req_read = 1'b1; bus.ack_in_read = 1'b1;
      step(); step();
      chk("hold_no_ack", {31'd0, bus.ack_read}, 32'd0);
      bus.ack_in_read = 1'b0;
      step();
      chk("hold_ack", {31'd0, bus.ack_read}, 32'd1);
      chk("hold_data", {16'd0, bus.data_out_dr}, 32'h5555);
      bus.req_read = 1'b0; bus.addr_dr = 8'h00;
      step(); step();
      chk("early_ack_held", {31'd0, bus.ack_read}, 32'd1);
      chk("early_data_held", {16'd0, bus.data_out_dr}, 32'h5555);
      bus.ack_in_read = 1'b1;
      step();
      chk("early_release", {31'd0, bus.ack_read}, 32'd0);
      bus.ack_in_read = 1'b0;

      // Randomized traffic, model-checked every cycle
      rst = 1'b1; step(); rst = 1'b0; step();
      for (int n = 0; n < 3000; n++) begin
         t = rnd_bus(4);
         bus.addr_dr     = t[7:0];
         bus.data_in_dr  = rnd_bus(8);
         bus.req_write   = ($urandom_range(0, 2) == 0);
         bus.req_read    = ($urandom_range(0, 2) == 0);
         bus.ack_in_read = ($urandom_range(0, 1) == 1);
         if (n == 1500) rst = 1'b1;
         if (n == 1502) rst = 1'b0;
         step();
      end
      idle_bus();
      rst = 1'b1; step(); rst = 1'b0; step();

      // Reset in the middle of a write handshake
      wr(9, 8'h11);
      bus.addr_dr = 8'h66; bus.data_in_dr = enc_d(8'h77, 8); bus.req_write = 1'b1;
      step();
      chk("mid_ack_write", {31'd0, bus.ack_write}, 32'd1);
      #1 rst = 1'b1;
      #1 chk("mid_async_clear", {31'd0, bus.ack_write}, 32'd0);
      idle_bus();
      step();
      rst = 1'b0;
      step();
      rd(5, 16'h5555);
      rd(9, 16'h5555);
      chk("mid_err_clear", {31'd0, bus.err}, 32'd0);

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
